// File: rtl/rr_grant_sequencer_pkg.sv
// Shared types and sizes for the four-requester round-robin grant sequencer.
// Optional hold timeout is compiled in with ARB_TIMEOUT_EN.
package rr_grant_sequencer_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_grant_sequencer_if;
    import rr_grant_sequencer_pkg::*;

    logic               enable_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    modport master (
        output enable_n,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  enable_n,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

// File: rtl/rr_grant_sequencer_pick4.sv
// Combinational 4-way rotating priority picker: first set request at or after ptr_i, wrapping.
module rr_pick4
    import rr_grant_sequencer_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    // Scanning from the farthest offset down lets the closest candidate to ptr_i win last.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter owning the grant index; one-hot grant is decoded from the registered index.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive grant cycles.
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_sequencer_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    rr_pick4 u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // The pointer advances at grant time, so an abort or timeout never rewinds priority.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                valid_d = 1'b0;
                if (!bus.enable_n && pick_valid) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    ptr_d   = pick_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (bus.enable_n || !bus.req[idx_q]) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt       = valid_q ? idx_to_onehot(idx_q) : '0;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule
